// File: rtl/muldiv_seq_if.sv
// Request/response bus between the EX-stage controller (master) and the
// sequential multiply/divide unit (slave).
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] result1;
    logic [WIDTH-1:0] result2;
    logic             busy;

    modport master (
        output req_valid, op, x, y, resp_ready,
        input  req_ready, resp_valid, result1, result2, busy
    );

    modport slave (
        input  req_valid, op, x, y, resp_ready,
        output req_ready, resp_valid, result1, result2, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish trivial operands in one cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int         CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] x_q, y_q;
    logic [3:0]       op_q;
    logic             short_q;
    logic [WIDTH-1:0] result1_q, result2_q;

    logic             accept;
    logic             start_short;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shifted;
    logic             div_ge;
    logic [WIDTH-1:0] short_r1, short_r2;

    assign accept         = bus.req_valid && (state == S_IDLE);
    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_DONE);
    assign bus.busy       = (state == S_MUL) || (state == S_DIV);
    assign bus.result1    = result1_q;
    assign bus.result2    = result2_q;

    // Operations that skip the iteration loop and resolve one cycle after accept
    always_comb begin
        start_short = 1'b0;
        if (bus.op == OP_DIV) begin
            start_short = (bus.y == '0);
        end else if (bus.op != OP_MUL) begin
            start_short = 1'b1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (bus.op == OP_MUL && (bus.x == '0 || bus.y == '0)) begin
            start_short = 1'b1;
        end
        if (bus.op == OP_DIV && bus.x < bus.y) begin
            start_short = 1'b1;
        end
`endif
    end

    // Iteration datapath: result2 is the high product / partial remainder,
    // result1 the low product / dividend shifting into quotient.
    always_comb begin
        mul_sum     = {1'b0, result2_q} + (result1_q[0] ? {1'b0, x_q} : '0);
        div_shifted = {result2_q, result1_q[WIDTH-1]};
        div_ge      = (div_shifted >= {1'b0, y_q});
        short_r1    = (op_q == OP_DIV && y_q == '0) ? '1 : '0;
        short_r2    = (op_q == OP_DIV) ? x_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Illegal ops park in S_DIV for one cycle with the short flag set
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (bus.op == OP_MUL) ? S_MUL : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (short_q || counter == '0) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            op_q      <= '0;
            short_q   <= 1'b0;
            result1_q <= '0;
            result2_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x_q       <= bus.x;
                        y_q       <= bus.y;
                        op_q      <= bus.op;
                        short_q   <= start_short;
                        counter   <= CNT_W'(WIDTH - 1);
                        result2_q <= '0;
                        result1_q <= (bus.op == OP_MUL) ? bus.y : bus.x;
                    end
                end
                S_MUL: begin
                    if (short_q) begin
                        result1_q <= short_r1;
                        result2_q <= short_r2;
                    end else begin
                        result2_q <= mul_sum[WIDTH:1];
                        result1_q <= {mul_sum[0], result1_q[WIDTH-1:1]};
                        counter   <= counter - 1'b1;
                    end
                end
                S_DIV: begin
                    if (short_q) begin
                        result1_q <= short_r1;
                        result2_q <= short_r2;
                    end else begin
                        result2_q <= div_ge ? WIDTH'(div_shifted - {1'b0, y_q})
                                            : div_shifted[WIDTH-1:0];
                        result1_q <= {result1_q[WIDTH-2:0], div_ge};
                        counter   <= counter - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32), hand-computed vectors.
module tb_muldiv_seq;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 32;
`endif

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic waitResp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Present a request, wait for the accept edge, then scramble the inputs
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a,
                                 input logic [31:0] b, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.op        = o;
        bus.x         = a;
        bus.y         = b;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.op        = 4'b1111;
        bus.x         = 32'hDEADBEEF;
        bus.y         = 32'h13;
        waitResp(lat);
    endtask

    task automatic takeResp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        checkOutput("resp_drop", 64'(bus.resp_valid), 64'd0);
    endtask

    task automatic runCase(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e1,
                           input logic [31:0] e2, input int elat);
        int lat;
        applyStimulus(o, a, b, lat);
        checkOutput({tag, "_lat"}, 64'(lat), 64'(elat));
        checkOutput({tag, "_r1"}, 64'(bus.result1), 64'(e1));
        checkOutput({tag, "_r2"}, 64'(bus.result2), 64'(e2));
        takeResp();
        checkOutput({tag, "_hold_r1"}, 64'(bus.result1), 64'(e1));
        checkOutput({tag, "_hold_r2"}, 64'(bus.result2), 64'(e2));
    endtask

    initial begin
        int lat;
        testsRun       = 0;
        testsFailed    = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.op         = 4'b0000;
        bus.x          = '0;
        bus.y          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_r1", 64'(bus.result1), 64'd0);
        checkOutput("rst_r2", 64'(bus.result2), 64'd0);

        runCase("mul_max", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32);
        runCase("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 32);
        runCase("div_msb_1", OP_DIV, 32'h80000000, 32'd1, 32'h80000000, 32'd0, 32);
        runCase("div_by0", OP_DIV, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1);
        runCase("illegal", 4'b0001, 32'd5, 32'd6, 32'd0, 32'd0, 1);
        runCase("mul_mixed", OP_MUL, 32'h12345678, 32'h10, 32'h23456780, 32'h1, 32);

        // Back-pressure in DONE with a request queued behind it
        applyStimulus(OP_MUL, 32'd3, 32'd5, lat);
        checkOutput("bp_lat", 64'(lat), 64'd32);
        bus.req_valid = 1'b1;
        bus.op        = OP_MUL;
        bus.x         = 32'd6;
        bus.y         = 32'd7;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bp_r1", 64'(bus.result1), 64'd15);
        checkOutput("bp_r2", 64'(bus.result2), 64'd0);
        checkOutput("bp_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        checkOutput("bp_req_ready_after", 64'(bus.req_ready), 64'd1);
        checkOutput("bp_resp_valid_after", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkOutput("queued_busy", 64'(bus.busy), 64'd1);
        waitResp(lat);
        checkOutput("queued_lat", 64'(lat), 64'd32);
        checkOutput("queued_r1", 64'(bus.result1), 64'd42);
        checkOutput("queued_r2", 64'(bus.result2), 64'd0);
        takeResp();

        // Reset in the middle of a division
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.op        = OP_DIV;
        bus.x         = 32'd1000;
        bus.y         = 32'd3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("mrst_req_ready", 64'(bus.req_ready), 64'd1);
        checkOutput("mrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        checkOutput("mrst_r1", 64'(bus.result1), 64'd0);
        checkOutput("mrst_r2", 64'(bus.result2), 64'd0);
        checkOutput("mrst_busy", 64'(bus.busy), 64'd0);
        runCase("div_9_3", OP_DIV, 32'd9, 32'd3, 32'd3, 32'd0, 32);

        runCase("div_small", OP_DIV, 32'd5, 32'd9, 32'd0, 32'd5, EARLY_LAT);
        runCase("mul_zero", OP_MUL, 32'd0, 32'd7, 32'd0, 32'd0, EARLY_LAT);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
